// File: rtl/types_pkg.sv
// Shared types and defaults for the data scoreboard.
//   sb_state_t         scoreboard FSM state (exported for debug)
//   instruction_item_t instruction that produced a reference-model result
//   data_item_t        one memory transaction (data, address, direction)
//   error_data_item_t  mismatch record emitted with err_valid
//   model_entry_t      element stored in the model-side FIFO
package types_pkg;

  localparam int SB_DEPTH_DEFAULT   = 8;
  localparam int SB_TIMEOUT_DEFAULT = 256;

  typedef enum logic [1:0] {
    SB_IDLE    = 2'd0,
    SB_WAIT    = 2'd1,
    SB_TIMEOUT = 2'd2
  } sb_state_t;

  // NO_INST / NO_TYPE must encode as zero so an all-zero record is well formed.
  typedef enum logic [3:0] {
    NO_INST  = 4'd0,
    INST_LB  = 4'd1,
    INST_LW  = 4'd2,
    INST_SB  = 4'd3,
    INST_SW  = 4'd4,
    INST_ADD = 4'd5
  } instruction_t;

  typedef enum logic [1:0] {
    NO_TYPE    = 2'd0,
    LOAD_TYPE  = 2'd1,
    STORE_TYPE = 2'd2,
    ALU_TYPE   = 2'd3
  } instruction_type_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } direction_t;

  typedef struct packed {
    instruction_t      instruction;
    instruction_type_t instruction_type;
    logic [31:0]       pc;
  } instruction_item_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    direction_t  direction;
  } data_item_t;

  typedef struct packed {
    instruction_item_t instr;
    data_item_t        model_data;
    data_item_t        dut_data;
    logic [2:0]        error_champ;
  } error_data_item_t;

  typedef struct packed {
    instruction_item_t instr;
    data_item_t        data;
  } model_entry_t;

  // bit 0: data, bit 1: addr, bit 2: direction
  function automatic logic [2:0] compare_items(input data_item_t exp_item,
                                               input data_item_t obs_item);
    logic [2:0] champ;
    champ[0] = (exp_item.data != obs_item.data);
    champ[1] = (exp_item.addr != obs_item.addr);
    champ[2] = (exp_item.direction != obs_item.direction);
    return champ;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers.
//   clk, rst         clock, synchronous active-high reset (empties the FIFO)
//   push, wr_data    write request and data; ignored while full
//   pop              read request; ignored while empty
//   rd_data          current head, valid while !empty
//   full, empty      status derived from the pointers
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     wr_data,
  input  logic pop,
  output T     rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  // Same index with differing MSB means the write pointer lapped the read pointer.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/data_scoreboard.sv
// Compares reference-model memory transactions against DUT transactions in order.
//   clk, rst                 clock, synchronous active-high reset
//   model_valid/ready        model-side handshake; model_instr + model_data pushed
//   dut_valid/ready          DUT-side handshake; dut_data pushed
//   err_valid, err_item      one-cycle mismatch pulse and its record
//   match_count              saturating count of clean comparisons
//   mismatch_count           saturating count of failed comparisons
//   timeout                  sticky: one side waited TIMEOUT cycles unmatched
//   state                    FSM state for debug
//
// state      | meaning
// SB_IDLE    | both FIFOs empty, or both non-empty and comparing
// SB_WAIT    | exactly one FIFO holds data; wait counter running
// SB_TIMEOUT | a wait expired; left only by reset, comparisons continue
module data_scoreboard
  import types_pkg::*;
#(
  parameter int DEPTH   = SB_DEPTH_DEFAULT,
  parameter int TIMEOUT = SB_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              model_valid,
  output logic              model_ready,
  input  instruction_item_t model_instr,
  input  data_item_t        model_data,
  input  logic              dut_valid,
  output logic              dut_ready,
  input  data_item_t        dut_data,
  output logic              err_valid,
  output error_data_item_t  err_item,
  output logic [15:0]       match_count,
  output logic [15:0]       mismatch_count,
  output logic              timeout,
  output sb_state_t         state
);

  localparam int              CW        = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT - 1);

  model_entry_t  m_in;
  model_entry_t  m_head;
  data_item_t    d_head;
  logic          m_full;
  logic          m_empty;
  logic          d_full;
  logic          d_empty;
  logic          cmp_pop;
  logic [2:0]    champ;
  logic [CW-1:0] wait_cnt;

  assign m_in        = '{instr: model_instr, data: model_data};
  assign model_ready = !m_full;
  assign dut_ready   = !d_full;
  assign cmp_pop     = !m_empty && !d_empty;
  assign champ       = compare_items(m_head.data, d_head);

  sync_fifo #(.T(model_entry_t), .DEPTH(DEPTH)) u_model_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (model_valid),
    .wr_data (m_in),
    .pop     (cmp_pop),
    .rd_data (m_head),
    .full    (m_full),
    .empty   (m_empty)
  );

  sync_fifo #(.T(data_item_t), .DEPTH(DEPTH)) u_dut_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (dut_valid),
    .wr_data (dut_data),
    .pop     (cmp_pop),
    .rd_data (d_head),
    .full    (d_full),
    .empty   (d_empty)
  );

  // err_item only changes on a mismatch, so it keeps the last failing record.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid      <= 1'b0;
      err_item       <= '0;
      match_count    <= '0;
      mismatch_count <= '0;
    end else begin
      err_valid <= 1'b0;
      if (cmp_pop) begin
        if (champ != 3'b000) begin
          err_valid <= 1'b1;
          err_item  <= '{instr:       m_head.instr,
                         model_data:  m_head.data,
                         dut_data:    d_head,
                         error_champ: champ};
          if (mismatch_count != 16'hFFFF) mismatch_count <= mismatch_count + 16'd1;
        end else if (match_count != 16'hFFFF) begin
          match_count <= match_count + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SB_IDLE;
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        SB_IDLE: begin
          if (m_empty != d_empty) begin
            state    <= SB_WAIT;
            wait_cnt <= '0;
          end
        end
        SB_WAIT: begin
          if (m_empty == d_empty) begin
            state <= SB_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= SB_TIMEOUT;
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SB_TIMEOUT: state <= SB_TIMEOUT;
        default:    state <= SB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_scoreboard.sv
module tb_data_scoreboard;
  import types_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              model_valid;
  logic              model_ready;
  instruction_item_t model_instr;
  data_item_t        model_data;
  logic              dut_valid;
  logic              dut_ready;
  data_item_t        dut_data;
  logic              err_valid;
  error_data_item_t  err_item;
  logic [15:0]       match_count;
  logic [15:0]       mismatch_count;
  logic              timeout;
  sb_state_t         state;

  data_scoreboard #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .model_valid    (model_valid),
    .model_ready    (model_ready),
    .model_instr    (model_instr),
    .model_data     (model_data),
    .dut_valid      (dut_valid),
    .dut_ready      (dut_ready),
    .dut_data       (dut_data),
    .err_valid      (err_valid),
    .err_item       (err_item),
    .match_count    (match_count),
    .mismatch_count (mismatch_count),
    .timeout        (timeout),
    .state          (state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference ----------------
  model_entry_t     mq[$];
  data_item_t       dq[$];
  logic             exp_err_valid;
  error_data_item_t exp_err_item;
  int               exp_match;
  int               exp_mismatch;
  logic             exp_timeout;
  int               run_len;      // consecutive edges seen with exactly one side holding data
  int               nm_acc;
  int               nd_acc;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic data_item_t gen_item(input int k);
    data_item_t d;
    d.data      = 32'h1000 + k;
    d.addr      = 32'h100 + (k * 4);
    d.direction = direction_t'(k[0]);
    return d;
  endfunction

  function automatic model_entry_t gen_entry(input int k);
    model_entry_t e;
    e.instr.instruction      = instruction_t'($urandom_range(0, 5));
    e.instr.instruction_type = instruction_type_t'($urandom_range(0, 3));
    e.instr.pc               = $urandom;
    e.data                   = gen_item(k);
    return e;
  endfunction

  // One compare process: every output against the reference after each edge.
  task automatic check_outputs();
    sb_state_t exp_state;
    exp_state = exp_timeout ? SB_TIMEOUT : ((run_len > 0) ? SB_WAIT : SB_IDLE);
    check("model_ready", model_ready, mq.size() < DEPTH);
    check("dut_ready", dut_ready, dq.size() < DEPTH);
    check("err_valid", err_valid, exp_err_valid);
    if (exp_err_valid) check("err_item", err_item, exp_err_item);
    check("match_count", match_count, exp_match[15:0]);
    check("mismatch_count", mismatch_count, exp_mismatch[15:0]);
    check("timeout", timeout, exp_timeout);
    check("state", state, exp_state);
  endtask

  // Apply one cycle of inputs, advance the reference by the same edge, compare.
  task automatic step(input logic r, input logic mv, input model_entry_t me,
                      input logic dv, input data_item_t dd);
    model_entry_t m;
    data_item_t   d;
    logic [2:0]   e;
    logic         push_m, push_d, both, one;
    rst         = r;
    model_valid = mv;
    model_instr = me.instr;
    model_data  = me.data;
    dut_valid   = dv;
    dut_data    = dd;
    exp_err_valid = 1'b0;
    if (r) begin
      mq.delete();
      dq.delete();
      exp_err_item = '0;
      exp_match    = 0;
      exp_mismatch = 0;
      exp_timeout  = 1'b0;
      run_len      = 0;
      nm_acc       = 0;
      nd_acc       = 0;
    end else begin
      push_m = mv && (mq.size() < DEPTH);
      push_d = dv && (dq.size() < DEPTH);
      both   = (mq.size() > 0) && (dq.size() > 0);
      one    = ((mq.size() > 0) != (dq.size() > 0));
      if (both) begin
        m = mq.pop_front();
        d = dq.pop_front();
        e = {m.data.direction != d.direction, m.data.addr != d.addr, m.data.data != d.data};
        if (e != 3'b000) begin
          exp_err_valid = 1'b1;
          exp_err_item  = '{instr: m.instr, model_data: m.data, dut_data: d, error_champ: e};
          if (exp_mismatch < 65535) exp_mismatch++;
        end else if (exp_match < 65535) begin
          exp_match++;
        end
      end
      if (push_m) begin mq.push_back(me); nm_acc++; end
      if (push_d) begin dq.push_back(dd); nd_acc++; end
      run_len = one ? run_len + 1 : 0;
      if (run_len == TIMEOUT + 1) exp_timeout = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_entry_t me;
    data_item_t   dd;
    int           pulses;
    logic [2:0]   champ_seen;
    int           pm, pd;

    rst = 1'b1; model_valid = 1'b0; dut_valid = 1'b0;
    model_instr = '0; model_data = '0; dut_data = '0;
    @(posedge clk);
    #1;
    do_reset();
    do_reset();
    check("reset_err_item", err_item, 171'd0);
    check("reset_state", state, SB_IDLE);
    check("reset_model_ready", model_ready, 1'b1);

    // single matching write pair
    me = '{instr: '{INST_SW, STORE_TYPE, 32'h40}, data: '{32'h1234, 32'h100, WRITE}};
    dd = '{32'h1234, 32'h100, WRITE};
    step(1'b0, 1'b1, me, 1'b1, dd);
    check("pair_cycle1_match", match_count, 16'd0);
    idle(1);
    check("pair_cycle2_match", match_count, 16'd1);
    check("pair_cycle2_err_valid", err_valid, 1'b0);
    idle(2);

    // address-only mismatch
    do_reset();
    dd = '{32'h1234, 32'h104, WRITE};
    step(1'b0, 1'b1, me, 1'b1, dd);
    pulses = 0;
    champ_seen = '0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (err_valid) begin pulses++; champ_seen = err_item.error_champ; end
    end
    check("addr_err_pulses", pulses, 1);
    check("addr_error_champ", champ_seen, 3'b010);

    // fill the model FIFO, then drain with matching DUT traffic
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, gen_entry(k), 1'b0, '0);
    check("full_model_ready", model_ready, 1'b0);
    step(1'b0, 1'b1, gen_entry(99), 1'b0, '0);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, '0, 1'b1, gen_item(k));
    idle(2);
    check("drain_match_count", match_count, 16'd8);
    check("drain_model_ready", model_ready, 1'b1);

    // reset with entries queued and a comparison about to happen
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, gen_entry(k), 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, gen_item(0));
    step(1'b1, 1'b1, gen_entry(5), 1'b1, gen_item(5));
    check("rst_model_ready", model_ready, 1'b1);
    check("rst_dut_ready", dut_ready, 1'b1);
    check("rst_match", match_count, 16'd0);
    check("rst_err_valid", err_valid, 1'b0);
    idle(2);
    check("rst_after_err_valid", err_valid, 1'b0);
    check("rst_after_state", state, SB_IDLE);

    // randomized traffic with varying per-side rates and occasional corruption
    do_reset();
    for (int seg = 0; seg < 10; seg++) begin
      pm = $urandom_range(20, 95);
      pd = $urandom_range(20, 95);
      for (int c = 0; c < 200; c++) begin
        dd = gen_item(nd_acc);
        if ($urandom_range(0, 99) < 12) dd.data[$urandom_range(0, 31)] ^= 1'b1;
        if ($urandom_range(0, 99) < 8)  dd.addr ^= 32'h4;
        if ($urandom_range(0, 99) < 8)  dd.direction = direction_t'(~dd.direction);
        step(1'b0, $urandom_range(0, 99) < pm, gen_entry(nm_acc),
             $urandom_range(0, 99) < pd, dd);
      end
      if (seg == 4) do_reset();
    end

    // lone model entry times out
    do_reset();
    step(1'b0, 1'b1, gen_entry(0), 1'b0, '0);
    idle(16);
    check("timeout_at_16", timeout, 1'b0);
    idle(1);
    check("timeout_at_17", timeout, 1'b1);
    check("timeout_state", state, SB_TIMEOUT);
    step(1'b0, 1'b0, '0, 1'b1, gen_item(0));
    idle(3);
    check("timeout_sticky", timeout, 1'b1);
    check("timeout_compare_continues", match_count, 16'd1);
    do_reset();
    check("timeout_cleared", timeout, 1'b0);

    // mismatch counter saturation
    do_reset();
    for (int k = 0; k < 65537; k++) begin
      dd = gen_item(k);
      dd.data = ~dd.data;
      step(1'b0, 1'b1, gen_entry(k), 1'b1, dd);
    end
    idle(3);
    check("mismatch_saturated", mismatch_count, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
